// File: rtl/rx_parity_deser.sv
// Serial receive deserializer: start bit, WIDTH data bits LSB-first, optional parity, stop bit.
// Consumes one pre-sampled bit per bit_strobe; all outputs are registered.
module rx_parity_deser #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             sampled_bit,
    input  logic             bit_strobe,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA,
    output logic             data_valid,
    output logic             par_err,
    output logic             stp_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [WIDTH-1:0] p_data_nxt;
    logic             par_en_q, par_en_nxt;
    logic             par_typ_q, par_typ_nxt;
    logic             par_bad, par_bad_nxt;
    logic             dv_nxt, pe_nxt, se_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            par_en_q   <= par_en_nxt;
            par_typ_q  <= par_typ_nxt;
            par_bad    <= par_bad_nxt;
            P_DATA     <= p_data_nxt;
            data_valid <= dv_nxt;
            par_err    <= pe_nxt;
            stp_err    <= se_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        par_en_nxt  = par_en_q;
        par_typ_nxt = par_typ_q;
        par_bad_nxt = par_bad;
        p_data_nxt  = P_DATA;
        dv_nxt      = 1'b0;
        pe_nxt      = 1'b0;
        se_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (bit_strobe && !sampled_bit) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    shift_nxt   = '0;
                    par_en_nxt  = PAR_EN;
                    par_typ_nxt = PAR_TYP;
                    par_bad_nxt = 1'b0;
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    // Shift in from the top so the first bit received ends up in bit 0.
                    shift_nxt   = {sampled_bit, shift_reg[WIDTH-1:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_strobe) begin
                    state_nxt = STOP;
                    if (sampled_bit != ((^shift_reg) ^ par_typ_q)) begin
                        pe_nxt      = 1'b1;
                        par_bad_nxt = 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    state_nxt = IDLE;
                    if (!sampled_bit) begin
                        se_nxt = 1'b1;
                    end else if (!par_bad) begin
                        dv_nxt     = 1'b1;
                        p_data_nxt = shift_reg;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_parity_deser.sv
// Directed and randomized frames against a frame-level reference model of the deserializer.
module tb_rx_parity_deser;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       bit_strobe = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_pdata = 8'h00;

    rx_parity_deser #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .sampled_bit(sampled_bit), .bit_strobe(bit_strobe),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic dv, input logic pe, input logic se,
                              input logic bz);
        check({tag, ".data_valid"}, {31'd0, data_valid}, {31'd0, dv});
        check({tag, ".par_err"},    {31'd0, par_err},    {31'd0, pe});
        check({tag, ".stp_err"},    {31'd0, stp_err},    {31'd0, se});
        check({tag, ".busy"},       {31'd0, busy},       {31'd0, bz});
        check({tag, ".P_DATA"},     {24'd0, P_DATA},     {24'd0, exp_pdata});
    endtask

    // Called at a falling edge; returns at the next falling edge with the strobe's effect visible.
    task automatic strobe(input logic b);
        sampled_bit = b;
        bit_strobe  = 1'b1;
        @(negedge CLK);
        bit_strobe  = 1'b0;
        sampled_bit = $urandom_range(0, 1);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check_outs("gap", 1'b0, 1'b0, 1'b0, busy);
        end
    endtask

    // Frame-level model: expected parity from the ones count, outcome from the stop bit.
    task automatic send_frame(input string tag, input logic [7:0] data, input logic pen,
                              input logic ptyp, input logic flip_par, input logic stop_bit,
                              input int gap, input logic toggle_cfg);
        logic pbit, exp_pe, exp_se, exp_dv;
        pbit   = logic'($countones(data) % 2) ^ ptyp ^ flip_par;
        exp_pe = pen && flip_par;
        exp_se = !stop_bit;
        exp_dv = stop_bit && !exp_pe;

        PAR_EN  = pen;
        PAR_TYP = ptyp;
        strobe(1'b0);
        check_outs({tag, ".start"}, 1'b0, 1'b0, 1'b0, 1'b1);
        if (toggle_cfg) begin
            PAR_EN  = ~pen;
            PAR_TYP = ~ptyp;
        end
        for (int i = 0; i < 8; i++) begin
            idle_gap(gap);
            strobe(data[i]);
            check_outs({tag, ".data"}, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        if (pen) begin
            idle_gap(gap);
            strobe(pbit);
            check_outs({tag, ".parity"}, 1'b0, exp_pe, 1'b0, 1'b1);
        end
        idle_gap(gap);
        strobe(stop_bit);
        if (exp_dv) exp_pdata = data;
        check_outs({tag, ".stop"}, exp_dv, 1'b0, exp_se, 1'b0);
    endtask

    initial begin
        // Reset state
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Idle-line strobes are ignored
        strobe(1'b1);
        check_outs("idle_one", 1'b0, 1'b0, 1'b0, 1'b0);

        send_frame("even_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("even_a5.value", {24'd0, P_DATA}, 32'hA5);
        idle_gap(1);

        // Odd parity selected but the even-parity bit (0) is sent
        send_frame("odd_a5_bad", 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        check("odd_a5_bad.held", {24'd0, P_DATA}, 32'hA5);
        idle_gap(2);

        send_frame("nopar_3c_stop0", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        idle_gap(1);
        send_frame("nopar_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("nopar_3c.value", {24'd0, P_DATA}, 32'h3C);
        idle_gap(1);

        // Parity and stop errors in the same frame
        send_frame("both_err", 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        idle_gap(1);

        // Sparse strobes, config toggled mid-frame
        send_frame("gap_81", 8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1);
        check("gap_81.value", {24'd0, P_DATA}, 32'h81);
        idle_gap(1);

        // Reset after 4 data bits
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        check("pre_rst.busy", {31'd0, busy}, 32'd1);
        RST = 1'b0;
        #1;
        exp_pdata = 8'h00;
        check_outs("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check_outs("mid_rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        send_frame("post_rst_5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("post_rst_5a.value", {24'd0, P_DATA}, 32'h5A);

        // Back-to-back: second start strobe lands in the data_valid cycle
        idle_gap(1);
        send_frame("b2b_11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame("b2b_ee", 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("b2b_ee.value", {24'd0, P_DATA}, 32'hEE);
        idle_gap(1);

        for (int f = 0; f < 40; f++) begin
            send_frame("rand", 8'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                       $urandom_range(0, 3), 1'($urandom));
            idle_gap($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
